// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder.
// Contents: sequencer state encoding, mvi opcode value and opcode field
// position (the top OP_W bits of every instruction word).
package instr_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Opcode occupies word[DW-1 -: OP_W]
  localparam int          OP_W   = 3;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;

endpackage

// File: rtl/instr_feeder_mem.sv
// Program memory for the instruction feeder: DEPTH x DW words,
// one synchronous write port and two asynchronous read ports.
// Ports:
//   clk            write clock
//   we/waddr/wdata write port (gated by the caller)
//   raddr0/rdata0  read port for the current word
//   raddr1/rdata1  read port for the following word (mvi immediate)
// Contents are never reset.
module feeder_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 6
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [DW-1:0]            rdata0,
  output logic [DW-1:0]            rdata1
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: steps through a stored program and presents each
// instruction to a simple processor, one Run pulse per instruction, waiting
// for Done before moving on. mvi (two-word) instructions present their
// immediate on Din while waiting.
// Ports:
//   Clock, Reset (async, active-high)
//   Start, Prog_len         : launch program of Prog_len words from word 0
//   Prog_we/addr/data       : program load (ignored while Busy)
//   Done                    : processor instruction-complete flag
//   Din, Run, Pc            : word, issue pulse and address to the processor
//   Busy, Complete, Err     : status
// Build option: define INSTR_FEEDER_TIMEOUT_EN to abort a wait that lasts
// TIMEOUT cycles after Run (sets Err, no Complete).
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DW      = 6,
  parameter int TIMEOUT = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Prog_we,
  input  logic [$clog2(DEPTH)-1:0] Prog_addr,
  input  logic [DW-1:0]            Prog_data,
  input  logic [$clog2(DEPTH):0]   Prog_len,
  input  logic                     Done,
  output logic [DW-1:0]            Din,
  output logic                     Run,
  output logic                     Busy,
  output logic                     Complete,
  output logic                     Err,
  output logic [$clog2(DEPTH)-1:0] Pc
);

  localparam int AW = $clog2(DEPTH);

  state_t        state, state_nx;
  logic [AW-1:0] pc_nx;
  logic [AW:0]   len_q, len_nx;
  logic          busy_nx, err_nx, cmpl_nx;
  logic [DW-1:0] word0, word1;
  logic          is_mvi, no_imm;
  logic [AW:0]   pc_step;

`ifdef INSTR_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt, cnt_nx;
`endif

  feeder_mem #(.DEPTH(DEPTH), .DW(DW)) u_mem (
    .clk    (Clock),
    .we     (Prog_we & ~Busy),
    .waddr  (Prog_addr),
    .wdata  (Prog_data),
    .raddr0 (Pc),
    .raddr1 (Pc + AW'(1)),
    .rdata0 (word0),
    .rdata1 (word1)
  );

  assign is_mvi  = (word0[DW-1 -: OP_W] == OP_MVI);
  // Extended by one bit so Pc+2 near the top of memory compares correctly
  assign pc_step = {1'b0, Pc} + {{(AW-1){1'b0}}, is_mvi, ~is_mvi};
  // mvi whose immediate would fall beyond the program length
  assign no_imm  = is_mvi && (({1'b0, Pc} + (AW+1)'(1)) >= len_q);

  always_comb begin
    state_nx = state;
    pc_nx    = Pc;
    len_nx   = len_q;
    busy_nx  = Busy;
    err_nx   = Err;
    cmpl_nx  = 1'b0;
    Run      = 1'b0;
    Din      = '0;
`ifdef INSTR_FEEDER_TIMEOUT_EN
    cnt_nx   = '0;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
          len_nx   = Prog_len;
          pc_nx    = '0;
          err_nx   = 1'b0;
          busy_nx  = 1'b1;
          state_nx = (Prog_len == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        Din = word0;
        if (no_imm) begin
          err_nx   = 1'b1;
          state_nx = FINISH;
        end else begin
          Run      = 1'b1;
          state_nx = WAIT;
`ifdef INSTR_FEEDER_TIMEOUT_EN
          cnt_nx   = TW'(1);
`endif
        end
      end
      WAIT: begin
        Din = is_mvi ? word1 : word0;
        if (Done) begin
          pc_nx    = pc_step[AW-1:0];
          state_nx = (pc_step < len_q) ? ISSUE : FINISH;
        end
`ifdef INSTR_FEEDER_TIMEOUT_EN
        // cnt holds cycles elapsed since Run; abort on the TIMEOUT-th
        else if (cnt == TW'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          state_nx = FINISH;
        end else begin
          cnt_nx   = cnt + TW'(1);
        end
`endif
      end
      FINISH: begin
        cmpl_nx  = ~Err;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      Pc       <= '0;
      len_q    <= '0;
      Busy     <= 1'b0;
      Err      <= 1'b0;
      Complete <= 1'b0;
    end else begin
      state    <= state_nx;
      Pc       <= pc_nx;
      len_q    <= len_nx;
      Busy     <= busy_nx;
      Err      <= err_nx;
      Complete <= cmpl_nx;
    end
  end

`ifdef INSTR_FEEDER_TIMEOUT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) cnt <= '0;
    else       cnt <= cnt_nx;
  end
`endif

endmodule

// File: tb/tb_instr_feeder.sv
module tb_instr_feeder;
  import instr_feeder_pkg::*;

  localparam int DEPTH   = 16;
  localparam int DW      = 6;
  localparam int TIMEOUT = 20;
  localparam int AW      = $clog2(DEPTH);

  logic          Clock, Reset, Start, Prog_we, Done;
  logic [AW-1:0] Prog_addr;
  logic [DW-1:0] Prog_data;
  logic [AW:0]   Prog_len;
  logic [DW-1:0] Din;
  logic          Run, Busy, Complete, Err;
  logic [AW-1:0] Pc;

  instr_feeder #(.DEPTH(DEPTH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Prog_we(Prog_we),
    .Prog_addr(Prog_addr), .Prog_data(Prog_data), .Prog_len(Prog_len),
    .Done(Done), .Din(Din), .Run(Run), .Busy(Busy), .Complete(Complete),
    .Err(Err), .Pc(Pc)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  // Scoreboard: expectations pushed with stimulus, observations from run
  int exp_din[$], exp_wait[$], exp_pc[$];
  int got_din[$], got_wait[$], got_pc[$], got_run_cyc[$];
  int runs, cmpls, cmpl_cyc, err_cyc;
  bit timed_out;

  localparam logic [DW-1:0] W_MV  = 6'b000_001;
  localparam logic [DW-1:0] W_ADD = 6'b010_100;
  localparam logic [DW-1:0] W_MVI = 6'b001_010;

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic load(input int addr, input logic [DW-1:0] data);
    Prog_we = 1'b1; Prog_addr = AW'(addr); Prog_data = data;
    tick();
    Prog_we = 1'b0;
  endtask

  // Launches the program and records what the DUT does until Busy falls.
  // delay: cycles from Run to Done (0 = never). poke: write word 0 while Busy.
  task automatic execute(input int len, input int delay, input int max_cyc, input bit poke);
    int cyc, cd;
    bit prev_run, stop;
    got_din.delete(); got_wait.delete(); got_pc.delete(); got_run_cyc.delete();
    runs = 0; cmpls = 0; cmpl_cyc = -1; err_cyc = -1; timed_out = 0;
    Prog_len = (AW+1)'(len); Start = 1'b1;
    tick();
    Start = 1'b0;
    cyc = 1; cd = 0; prev_run = 0; stop = 0;
    while (!stop) begin
      if (prev_run) got_wait.push_back(int'(Din));
      if (Run) begin
        runs++;
        got_din.push_back(int'(Din));
        got_pc.push_back(int'(Pc));
        got_run_cyc.push_back(cyc);
      end
      if (Complete) begin cmpls++; if (cmpl_cyc < 0) cmpl_cyc = cyc; end
      if (Err && err_cyc < 0) err_cyc = cyc;
      if (!Busy) stop = 1;
      else if (cyc >= max_cyc) begin timed_out = 1; stop = 1; end
      else begin
        Done = 1'b0;
        if (cd > 0) begin cd--; if (cd == 0) Done = 1'b1; end
        if (Run && delay > 0) cd = delay;
        Prog_we = poke && (cyc == 2); Prog_addr = '0; Prog_data = 6'h3F;
        prev_run = Run;
        tick();
        cyc++;
      end
    end
    Done = 1'b0; Prog_we = 1'b0;
    if (!timed_out) begin
      tick();
      if (Complete) cmpls++;
    end
  endtask

  // Pops every pending expectation and compares against observations
  task automatic check_queues(input string tag);
    int e, g;
    while (exp_din.size() > 0) begin
      e = exp_din.pop_front(); g = (got_din.size() > 0) ? got_din.pop_front() : -1;
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s run_din got=%0h exp=%0h", tag, g, e); end
    end
    while (exp_wait.size() > 0) begin
      e = exp_wait.pop_front(); g = (got_wait.size() > 0) ? got_wait.pop_front() : -1;
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s wait_din got=%0h exp=%0h", tag, g, e); end
    end
    while (exp_pc.size() > 0) begin
      e = exp_pc.pop_front(); g = (got_pc.size() > 0) ? got_pc.pop_front() : -1;
      checks++;
      if (g !== e) begin failures++; $display("FAIL %s run_pc got=%0d exp=%0d", tag, g, e); end
    end
  endtask

  task automatic test_reset();
    checks++; if (Din !== '0) begin failures++; $display("FAIL reset_din got=%0h exp=0", Din); end
    checks++; if (Run !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", Run); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Complete !== 1'b0) begin failures++; $display("FAIL reset_complete got=%b exp=0", Complete); end
    checks++; if (Err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", Err); end
    checks++; if (Pc !== '0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", Pc); end
  endtask

  task automatic test_two_word();
    load(0, W_MV); load(1, W_ADD);
    exp_din.push_back(W_MV); exp_din.push_back(W_ADD);
    exp_wait.push_back(W_MV); exp_wait.push_back(W_ADD);
    exp_pc.push_back(0); exp_pc.push_back(1);
    execute(2, 3, 100, 0);
    checks++; if (runs !== 2) begin failures++; $display("FAIL two_word runs got=%0d exp=2", runs); end
    checks++; if (cmpls !== 1) begin failures++; $display("FAIL two_word complete got=%0d exp=1", cmpls); end
    checks++; if (Err !== 1'b0) begin failures++; $display("FAIL two_word err got=%b exp=0", Err); end
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL two_word bound got=%b exp=0", timed_out); end
    // Done 3 cycles after Run, next Run the cycle after Done
    checks++;
    if (got_run_cyc.size() != 2 || got_run_cyc[1] - got_run_cyc[0] != 4) begin
      failures++; $display("FAIL back_to_back run_gap got=%0d exp=4",
                           (got_run_cyc.size() == 2) ? got_run_cyc[1] - got_run_cyc[0] : -1);
    end
    check_queues("two_word");
  endtask

  task automatic test_mvi();
    load(0, W_MVI); load(1, 6'h2A);
    exp_din.push_back(W_MVI); exp_wait.push_back(6'h2A); exp_pc.push_back(0);
    execute(2, 3, 100, 0);
    checks++; if (runs !== 1) begin failures++; $display("FAIL mvi runs got=%0d exp=1", runs); end
    checks++; if (Pc !== AW'(2)) begin failures++; $display("FAIL mvi pc_end got=%0d exp=2", Pc); end
    checks++; if (cmpls !== 1) begin failures++; $display("FAIL mvi complete got=%0d exp=1", cmpls); end
    check_queues("mvi");
  endtask

  task automatic test_mixed();
    load(0, W_MV); load(1, W_MVI); load(2, 6'h15); load(3, W_ADD);
    exp_din.push_back(W_MV); exp_din.push_back(W_MVI); exp_din.push_back(W_ADD);
    exp_wait.push_back(W_MV); exp_wait.push_back(6'h15); exp_wait.push_back(W_ADD);
    exp_pc.push_back(0); exp_pc.push_back(1); exp_pc.push_back(3);
    execute(4, 2, 100, 0);
    checks++; if (runs !== 3) begin failures++; $display("FAIL mixed runs got=%0d exp=3", runs); end
    checks++; if (cmpls !== 1) begin failures++; $display("FAIL mixed complete got=%0d exp=1", cmpls); end
    check_queues("mixed");
  endtask

  task automatic test_zero_len();
    execute(0, 3, 50, 0);
    checks++; if (runs !== 0) begin failures++; $display("FAIL zero_len runs got=%0d exp=0", runs); end
    checks++; if (cmpl_cyc !== 2) begin failures++; $display("FAIL zero_len complete_cycle got=%0d exp=2", cmpl_cyc); end
    checks++; if (cmpls !== 1) begin failures++; $display("FAIL zero_len complete got=%0d exp=1", cmpls); end
  endtask

  task automatic test_mvi_last();
    load(0, W_MVI);
    execute(1, 3, 50, 0);
    checks++; if (runs !== 0) begin failures++; $display("FAIL mvi_last runs got=%0d exp=0", runs); end
    checks++; if (Err !== 1'b1) begin failures++; $display("FAIL mvi_last err got=%b exp=1", Err); end
    checks++; if (cmpls !== 0) begin failures++; $display("FAIL mvi_last complete got=%0d exp=0", cmpls); end
  endtask

  task automatic test_reset_mid();
    load(0, W_MV); load(1, W_ADD);
    Prog_len = (AW+1)'(2); Start = 1'b1;
    tick(); Start = 1'b0;          // ISSUE Pc=0
    tick(); Done = 1'b1;           // WAIT
    tick(); Done = 1'b0;           // ISSUE Pc=1
    tick();                        // WAIT Pc=1
    checks++;
    if (Busy !== 1'b1 || Pc !== AW'(1)) begin
      failures++; $display("FAIL reset_mid pre got=busy%b/pc%0d exp=busy1/pc1", Busy, Pc);
    end
    Reset = 1'b1;
    tick();
    test_reset();
    Reset = 1'b0;
    tick();
    exp_din.push_back(W_MV); exp_din.push_back(W_ADD);
    exp_pc.push_back(0); exp_pc.push_back(1);
    execute(2, 1, 100, 0);
    checks++; if (cmpls !== 1) begin failures++; $display("FAIL reset_mid rerun_complete got=%0d exp=1", cmpls); end
    check_queues("reset_mid");
  endtask

  task automatic test_timeout();
    load(0, W_MV);
`ifdef INSTR_FEEDER_TIMEOUT_EN
    execute(1, 0, 200, 1);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL timeout bound got=%b exp=0", timed_out); end
    checks++;
    if (got_run_cyc.size() != 1 || err_cyc - got_run_cyc[0] != TIMEOUT) begin
      failures++; $display("FAIL timeout err_delay got=%0d exp=%0d",
                           (got_run_cyc.size() == 1) ? err_cyc - got_run_cyc[0] : -1, TIMEOUT);
    end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL timeout busy got=%b exp=0", Busy); end
    checks++; if (cmpls !== 0) begin failures++; $display("FAIL timeout complete got=%0d exp=0", cmpls); end
`else
    execute(1, 0, 3 * TIMEOUT, 1);
    checks++; if (timed_out !== 1'b1) begin failures++; $display("FAIL hold still_busy got=%b exp=1", timed_out); end
    checks++; if (Err !== 1'b0) begin failures++; $display("FAIL hold err got=%b exp=0", Err); end
    Done = 1'b1; tick(); Done = 1'b0; tick();
    checks++;
    if (Complete !== 1'b1 || Busy !== 1'b0) begin
      failures++; $display("FAIL hold release got=cmpl%b/busy%b exp=cmpl1/busy0", Complete, Busy);
    end
`endif
    // The write attempted while Busy must not have landed
    exp_din.push_back(W_MV);
    execute(1, 2, 100, 0);
    check_queues("write_while_busy");
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Prog_we = 1'b0; Done = 1'b0;
    Prog_addr = '0; Prog_data = '0; Prog_len = '0;
    tick(); tick();
    test_reset();
    Reset = 1'b0;
    tick();
    test_two_word();
    test_mvi();
    test_mixed();
    test_zero_len();
    test_mvi_last();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 Parameter DEPTH, default 16, program memory words (power of two).
REQ-002 Parameter DW, default 6, instruction/data word width, equal to the processor Din/Bus width.
REQ-003 Parameter TIMEOUT, default 255, max cycles to wait for Done (timeout build only).
REQ-004 Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Start  input  1  level; sampled in IDLE to begin executing the stored program from word 0.
REQ-007 Prog_we  input  1  program memory write strobe.
REQ-008 Prog_addr  input  log2(DEPTH)  program memory write address.
REQ-009 Prog_data  input  DW  program memory write data.
REQ-010 Prog_len  input  log2(DEPTH)+1  number of valid program words, 0..DEPTH, sampled on Start.
REQ-011 Done  input  1  processor instruction-complete flag.
REQ-012 Din  output  DW  word presented to the processor.
REQ-013 Run  output  1  one-cycle instruction-issue pulse to the processor.
REQ-014 Busy  output  1  high from Start acceptance until program end or abort.
REQ-015 Complete  output  1  one-cycle pulse when the program finishes normally.
REQ-016 Err  output  1  sticky error flag, cleared on next accepted Start or Reset.
REQ-017 Pc  output  log2(DEPTH)  address of the word currently issued.

Function
REQ-018 Opcode is Din[DW-1:DW-3]; opcode 3'b001 (mvi) is two-word (instruction + immediate), all others one word.
REQ-019 States: IDLE, ISSUE, WAIT, FINISH.
REQ-020 IDLE: Start=1 latches Prog_len, Pc<=0, clears Err, Busy<=1; next state ISSUE, or FINISH if Prog_len=0.
REQ-021 ISSUE (exactly one cycle): Din=mem[Pc], Run=1; next WAIT.
REQ-022 WAIT: Run=0; Din=mem[Pc+1] for mvi, else mem[Pc] held; Done=1 advances Pc by 2 (mvi) or 1.
REQ-023 After Done, next state ISSUE if new Pc < latched length, else FINISH; back-to-back issue gives 1 idle-free cycle between Done and next Run.
REQ-024 mvi at the last valid word (no immediate): no Run issued, Err<=1, go FINISH.
REQ-025 FINISH (one cycle): Complete=1 unless Err set, Busy<=0, next IDLE.
REQ-026 Done in any state other than WAIT is ignored; Start while Busy is ignored.
REQ-027 Prog_we writes mem[Prog_addr] only when Busy=0; writes while Busy are dropped.
REQ-028 Din=0 in IDLE and FINISH.

Reset
REQ-029 Reset asserted: state IDLE, Din=0, Run=0, Busy=0, Complete=0, Err=0, Pc=0, timeout counter 0, mid-program included; memory contents unchanged.

Configuration
REQ-030 Macro INSTR_FEEDER_TIMEOUT_EN defined: counter runs in WAIT; reaching TIMEOUT without Done sets Err, goes FINISH (no Complete).
REQ-031 Macro undefined: no counter; WAIT holds indefinitely until Done or Reset.

Structure
REQ-032 Shared package holds the state enum, opcode constant OP_MVI=3'b001, and opcode field position.
REQ-033 Program memory is sub-module feeder_mem (DEPTH x DW, one sync write port, one async read port pair: Pc and Pc+1).

Verification
REQ-034 Load {mv,add}, Prog_len=2, Start, Done 3 cycles after each Run -> two Run pulses, Din=word0 then word1, one Complete, Err=0.
REQ-035 Load {mvi,6'h2A}, Prog_len=2 -> one Run, Din=6'h2A during WAIT, Pc 0->2, Complete.
REQ-036 Prog_len=0, Start -> no Run, Complete pulse two cycles after Start.
REQ-037 Prog_len=1, word0=mvi -> no Run, Err=1, no Complete.
REQ-038 Reset pulsed while in WAIT -> all outputs at reset values next cycle; new Start reruns from Pc=0.
REQ-039 TIMEOUT_EN, Done never asserted -> Err=1 exactly TIMEOUT cycles after Run, Busy falls; Prog_we during Busy leaves memory unchanged.
